inv_key_expand: RTL and testbench
=================================

INV_KEY_EXPAND -- requirements
Module: inv_key_expand

Interface
REQ-001 Parameter NR, default 10, is the index of the supplied round key; legal range 1..10. Round 0 is the AES-128 cipher key.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin inverse expansion; sampled at rising edge.
REQ-005 key_in  input  128  round-NR key; word w0 = [127:96], w3 = [31:0]; sampled only on the accepted start edge.
REQ-006 busy  output  1  high while inverse expansion is in progress.
REQ-007 round_valid  output  1  high when round_key/round_idx carry a valid round key.
REQ-008 round_key  output  128  current round key, descending order.
REQ-009 round_idx  output  4  index of round_key, from NR down to 0.
REQ-010 done  output  1  one-cycle pulse coincident with round_idx = 0.
REQ-011 key_out  output  128  recovered cipher key (round 0); holds until next completion.

Function
REQ-012 Inverse round step, given round key (w0,w1,w2,w3) with index i (i ≥ 1), shall produce round i-1 key (v0,v1,v2,v3) as follows:
- v3 = w3^w2
- v2 = w2^w1
- v1 = w1^w0
- v0 = w0 ^ SubWord(RotWord(v3)) ^ {Rcon(i),24'h0}
REQ-013 RotWord shall rotate bytes left by one, so [b0 b1 b2 b3] becomes [b1 b2 b3 b0]. SubWord shall apply the forward AES S-box to each byte.
REQ-014 Rcon(1..10) shall be 01,02,04,08,10,20,40,80,1b,36, from a table or by inverse xtime: 1b becomes 80; otherwise shift right by 1.
REQ-015 Start acceptance: start=1 with busy=0 at edge E0 shall load key_in. After E0:
- round_valid=1, round_key=key_in, round_idx=NR
- busy=1
REQ-016 Each later edge Ek (k=1..NR) shall apply one inverse step. After Ek, round_key = round NR-k key and round_idx = NR-k. One round per cycle; NR+1 valid cycles total.
REQ-017 After E(NR):
- done=1 and key_out = round 0 key
- busy=0, round_valid=1
REQ-018 After E(NR+1), if no new start is accepted: round_valid=0 and done=0. round_key and round_idx shall hold their last values.
REQ-019 start while busy=1 shall be ignored; no restart and no effect on the sequence in flight.
REQ-020 start=1 on the done cycle (busy=0) shall be accepted at the next edge. That edge is the E0 of a new run, so round_valid stays high without a gap.
REQ-021 done shall never be high for more than one consecutive cycle except on back-to-back runs with NR=0. NR=0 is illegal, so this exception never applies.
REQ-022 key_out shall change only on the done cycle.

Reset
REQ-023 rst=1 shall immediately, without waiting for clk, force all of the following: busy=0, round_valid=0, done=0, round_idx=0, round_key=0, key_out=0, internal Rcon/counter state idle.
REQ-024 rst asserted mid-run shall abort the run with no done pulse. The first accepted start after rst deassertion shall begin a fresh run.
REQ-025 start sampled while rst=1 shall be ignored.

Verification
REQ-026 Vector 1, NR=10: key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 and one-cycle start. Required response:
- round_idx=9 key ac7766f319fadc2128d12941575c006e
- round_idx=1 key a0fafe1788542cb123a339392a6c7605
- done after 10 edges past E0, with key_out=2b7e151628aed2a6abf7158809cf4f3c
REQ-027 Vector 2, NR=10: key_in=13111d7fe3944a17f307a78b4d2b30c5. Required response: key_out=000102030405060708090a0b0c0d0e0f, with busy high for exactly 10 cycles.
REQ-028 Pulse start at round_idx=5 during the vector 1 run. Required response: the sequence is unchanged, and done is high exactly once at the expected cycle.
REQ-029 Assert rst for 1 ns between edges at round_idx=4. Required response: all outputs are 0 immediately and no done occurs. Then rerun vector 2, which shall complete correctly.
REQ-030 Hold start high across the vector 1 done cycle with key_in switched to vector 2. Required response:
- a second run starts at the next edge
- round_valid is continuous across the boundary
- final key_out = 000102030405060708090a0b0c0d0e0f
REQ-031 NR=1: key_in=a0fafe1788542cb123a339392a6c7605. Required response: exactly 2 valid cycles (idx 1 then 0), and done on the second with key_out=2b7e151628aed2a6abf7158809cf4f3c.

Source files
------------

// File: rtl/inv_key_expand.sv
// AES-128 inverse key expansion: walks from the round-NR key back to the cipher key,
// presenting one round key per cycle in descending order.
module inv_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         round_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         done,
  output logic [127:0] key_out
);

  // Forward S-box, byte x stored at bit offset 8*(255-x).
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon_of(input int i);
    case (i)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  localparam logic [7:0] RCON_NR = rcon_of(NR);
  localparam logic [3:0] NR_IDX  = 4'(NR);

  logic [7:0]   rcon_reg;
  logic [7:0]   rcon_next;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  v0, v1, v2, v3;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [127:0] step_key_next;

  assign w0 = round_key[127:96];
  assign w1 = round_key[95:64];
  assign w2 = round_key[63:32];
  assign w3 = round_key[31:0];

  assign v3       = w3 ^ w2;
  assign v2       = w2 ^ w1;
  assign v1       = w1 ^ w0;
  assign rot_word = {v3[23:0], v3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sub
      assign sub_word[8*gi +: 8] = sbox(rot_word[8*gi +: 8]);
    end
  endgenerate

  assign v0            = w0 ^ sub_word ^ {rcon_reg, 24'h0};
  assign step_key_next = {v0, v1, v2, v3};

  // Rcon walks backwards: 1b precedes 80, every other step is a right shift.
  assign rcon_next = (rcon_reg == 8'h1b) ? 8'h80 : {1'b0, rcon_reg[7:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      round_valid <= 1'b0;
      round_key   <= '0;
      round_idx   <= '0;
      done        <= 1'b0;
      key_out     <= '0;
      rcon_reg    <= '0;
    end else if (start && !busy) begin
      round_key   <= key_in;
      round_idx   <= NR_IDX;
      round_valid <= 1'b1;
      busy        <= 1'b1;
      done        <= 1'b0;
      rcon_reg    <= RCON_NR;
    end else if (busy) begin
      round_key <= step_key_next;
      round_idx <= round_idx - 4'd1;
      rcon_reg  <= rcon_next;
      if (round_idx == 4'd1) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        key_out <= step_key_next;
      end
    end else begin
      round_valid <= 1'b0;
      done        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inv_key_expand.sv
// Bench for inv_key_expand: whole-schedule reference model checked every cycle,
// directed vectors, start/reset corner cases and randomized traffic.
module tb_inv_key_expand;

  localparam logic [127:0] V1_IN  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] V1_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] V1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] V1_OUT = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2_IN  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] V2_OUT = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, start1;
  logic [127:0] key_in, key_in1;
  logic         busy, round_valid, done;
  logic [127:0] round_key, key_out;
  logic [3:0]   round_idx;
  logic         busy1, round_valid1, done1;
  logic [127:0] round_key1, key_out1;
  logic [3:0]   round_idx1;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  bit model_on = 1'b0;

  inv_key_expand #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
    .round_valid(round_valid), .round_key(round_key), .round_idx(round_idx),
    .done(done), .key_out(key_out)
  );

  inv_key_expand #(.NR(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key_in(key_in1), .busy(busy1),
    .round_valid(round_valid1), .round_key(round_key1), .round_idx(round_idx1),
    .done(done1), .key_out(key_out1)
  );

  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  logic [7:0] sb [256];
  logic [7:0] rc [1:10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    rc[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rc[i] = gmul(rc[i-1], 8'h02);
  endtask

  function automatic logic [127:0] inv_step(input logic [127:0] k, input int i);
    logic [31:0] w0, w1, w2, w3, v3, t, s;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    v3 = w3 ^ w2;
    t  = {v3[23:0], v3[31:24]};
    s  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    return {w0 ^ s ^ {rc[i], 24'h0}, w1 ^ w0, w2 ^ w1, v3};
  endfunction

  // Full schedule for a round-10 key; slot i holds round i.
  function automatic logic [1407:0] schedule(input logic [127:0] k10);
    logic [1407:0] s;
    logic [127:0]  k;
    k = k10;
    s[128*10 +: 128] = k;
    for (int i = 10; i >= 1; i--) begin
      k = inv_step(k, i);
      s[128*(i-1) +: 128] = k;
    end
    return s;
  endfunction

  // ---------------- cycle model for the NR=10 instance ----------------
  logic [1407:0] m_sched;
  int            m_cur;
  logic          m_valid;
  logic [127:0]  m_key, m_kout;
  logic [3:0]    m_idx;
  logic          m_busy, m_done;

  assign m_busy = m_valid && (m_cur > 0);
  assign m_done = m_valid && (m_cur == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_cur   <= 0;
      m_key   <= '0;
      m_idx   <= '0;
      m_kout  <= '0;
    end else if (start && !m_busy) begin
      m_sched <= schedule(key_in);
      m_cur   <= 10;
      m_valid <= 1'b1;
      m_key   <= key_in;
      m_idx   <= 4'd10;
    end else if (m_busy) begin
      m_cur <= m_cur - 1;
      m_key <= m_sched[128*(m_cur-1) +: 128];
      m_idx <= 4'(m_cur - 1);
      if (m_cur == 1) m_kout <= m_sched[127:0];
    end else begin
      m_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_count++;
    if (model_on && !rst) begin
      chk("busy", 128'(busy), 128'(m_busy));
      chk("round_valid", 128'(round_valid), 128'(m_valid));
      chk("round_idx", 128'(round_idx), 128'(m_idx));
      chk("round_key", round_key, m_key);
      chk("done", 128'(done), 128'(m_done));
      chk("key_out", key_out, m_kout);
    end
  end

  // Pulse start for one cycle; returns at the negedge after E0.
  task automatic kick(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Follows a run until done; optionally pokes start at round 5.
  task automatic follow(input bit poke5, output int cyc, output int busy_cyc,
                        output logic [127:0] k9, output logic [127:0] k1);
    bit seen = 1'b0;
    cyc = 0; busy_cyc = busy ? 1 : 0; k9 = '0; k1 = '0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) busy_cyc++;
      if (round_idx == 4'd9) k9 = round_key;
      if (round_idx == 4'd1) k1 = round_key;
      if (poke5 && round_idx == 4'd5) begin
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      if (done) seen = 1'b1;
    end
    chk("done_seen", 128'(seen), 128'(1));
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (round_idx == idx && round_valid) seen = 1'b1;
    end
    chk("idx_reached", 128'(seen), 128'(1));
  endtask

  initial begin
    int cyc, bcyc, dc0, runs;
    logic [127:0] k9, k1;
    logic [1407:0] s;

    rst = 1'b1; start = 1'b0; start1 = 1'b0; key_in = '0; key_in1 = '0;
    build_tables();

    // Pin the model to hand-known values.
    chk("model_sbox00", 128'(sb[0]), 128'h63);
    chk("model_sbox53", 128'(sb[8'h53]), 128'hed);
    chk("model_rcon10", 128'(rc[10]), 128'h36);
    s = schedule(V1_IN);
    chk("model_v1_r9", s[128*9 +: 128], V1_R9);
    chk("model_v1_r1", s[128*1 +: 128], V1_R1);
    chk("model_v1_r0", s[127:0], V1_OUT);
    s = schedule(V2_IN);
    chk("model_v2_r0", s[127:0], V2_OUT);

    // Reset state, with start held during reset.
    @(negedge clk);
    start = 1'b1; key_in = V1_IN;
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(round_valid), 128'(0));
    chk("rst_key", round_key, 128'(0));
    chk("rst_idx", 128'(round_idx), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_key_out", key_out, 128'(0));
    chk("rst_key_out1", key_out1, 128'(0));
    start = 1'b0;
    rst   = 1'b0;
    model_on = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", 128'(round_valid), 128'(0));

    // Vector 1 with an ignored start at round 5.
    dc0 = done_count;
    kick(V1_IN);
    chk("v1_e0_idx", 128'(round_idx), 128'(10));
    follow(1'b1, cyc, bcyc, k9, k1);
    chk("v1_cycles", 128'(cyc), 128'(10));
    chk("v1_r9", k9, V1_R9);
    chk("v1_r1", k1, V1_R1);
    chk("v1_key_out", key_out, V1_OUT);
    @(negedge clk);
    chk("v1_valid_drop", 128'(round_valid), 128'(0));
    chk("v1_key_hold", round_key, V1_OUT);
    @(negedge clk);
    chk("v1_done_once", 128'(done_count - dc0), 128'(1));
    $display("txn vector1: key_out=%h cycles=%0d", key_out, cyc);

    // Vector 2, busy duration.
    kick(V2_IN);
    follow(1'b0, cyc, bcyc, k9, k1);
    chk("v2_busy_cycles", 128'(bcyc), 128'(10));
    chk("v2_key_out", key_out, V2_OUT);
    $display("txn vector2: key_out=%h busy=%0d", key_out, bcyc);
    repeat (2) @(negedge clk);

    // Abort at round 4, then rerun vector 2.
    dc0 = done_count;
    kick(V1_IN);
    wait_idx(4'd4);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_valid", 128'(round_valid), 128'(0));
    chk("abort_idx", 128'(round_idx), 128'(0));
    chk("abort_key", round_key, 128'(0));
    chk("abort_key_out", key_out, 128'(0));
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_no_done", 128'(done_count - dc0), 128'(0));
    kick(V2_IN);
    follow(1'b0, cyc, bcyc, k9, k1);
    chk("abort_rerun", key_out, V2_OUT);
    $display("txn abort+rerun: key_out=%h", key_out);
    repeat (2) @(negedge clk);

    // Back-to-back: start held through the done cycle.
    kick(V1_IN);
    wait_idx(4'd1);
    key_in = V2_IN;
    start  = 1'b1;
    @(negedge clk);
    chk("b2b_done", 128'(done), 128'(1));
    chk("b2b_first_out", key_out, V1_OUT);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_valid", 128'(round_valid), 128'(1));
    chk("b2b_idx", 128'(round_idx), 128'(10));
    chk("b2b_key", round_key, V2_IN);
    follow(1'b0, cyc, bcyc, k9, k1);
    chk("b2b_final_out", key_out, V2_OUT);
    $display("txn back-to-back: key_out=%h", key_out);
    repeat (2) @(negedge clk);

    // NR=1 instance.
    key_in1 = V1_R1;
    start1  = 1'b1;
    @(negedge clk);
    start1  = 1'b0;
    chk("nr1_e0_valid", 128'(round_valid1), 128'(1));
    chk("nr1_e0_idx", 128'(round_idx1), 128'(1));
    chk("nr1_e0_key", round_key1, V1_R1);
    chk("nr1_e0_busy", 128'(busy1), 128'(1));
    @(negedge clk);
    chk("nr1_e1_idx", 128'(round_idx1), 128'(0));
    chk("nr1_e1_key", round_key1, V1_OUT);
    chk("nr1_e1_done", 128'(done1), 128'(1));
    chk("nr1_e1_busy", 128'(busy1), 128'(0));
    chk("nr1_key_out", key_out1, V1_OUT);
    @(negedge clk);
    chk("nr1_e2_valid", 128'(round_valid1), 128'(0));
    chk("nr1_e2_done", 128'(done1), 128'(0));
    chk("nr1_e2_idx", 128'(round_idx1), 128'(0));
    $display("txn nr1: key_out=%h", key_out1);

    // Randomized traffic; the per-cycle model compare does the checking.
    runs = 0;
    for (int n = 0; n < 2000; n++) begin
      int r;
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      start = 1'b0;
      if (r < 10) begin
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        if (!busy) runs++;
      end else if (r == 10) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    start = 1'b0;
    repeat (15) @(negedge clk);
    $display("txn random: %0d start requests while idle", runs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
